// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one single-port data memory between two requesters.
// Latency: req seen in cycle t -> gnt/memory access in t+1 -> registered rvalid/rdata/err in t+2.
// Backpressure: requesters hold req until gnt; the port just served is masked for one cycle.
module dmem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int DIPTH    = 100,
  parameter int CNT_BITS = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [WIDTH-1:0]    m0_addr,
  input  logic [WIDTH-1:0]    m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [WIDTH-1:0]    m0_rdata,
  output logic                m0_err,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [WIDTH-1:0]    m1_addr,
  input  logic [WIDTH-1:0]    m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [WIDTH-1:0]    m1_rdata,
  output logic                m1_err,
  output logic [WIDTH-1:0]    mem_A,
  output logic [WIDTH-1:0]    mem_WD,
  output logic                mem_WE,
  input  logic [WIDTH-1:0]    mem_RD,
  output logic [CNT_BITS-1:0] conflict_cnt
);

  localparam logic [WIDTH-1:0] LIMIT = WIDTH'(DIPTH);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t              state, state_nxt;
  logic                owner, owner_nxt;
  logic                rr_ptr, rr_nxt;
  logic                cnt_inc;
  logic [CNT_BITS-1:0] cnt;
  logic                eff_req0, eff_req1;
  logic                sel_we;
  logic [WIDTH-1:0]    sel_addr, sel_wdata;
  logic                in_range;
  logic [WIDTH-1:0]    resp_data;

  // The port owning the current ACCESS cycle cannot win the next one, so a held req is never granted twice.
  assign eff_req0 = m0_req & ~((state == ACCESS) & (owner == 1'b0));
  assign eff_req1 = m1_req & ~((state == ACCESS) & (owner == 1'b1));

  assign sel_we    = owner ? m1_we    : m0_we;
  assign sel_addr  = owner ? m1_addr  : m0_addr;
  assign sel_wdata = owner ? m1_wdata : m0_wdata;
  assign in_range  = (sel_addr < LIMIT);

  // Writes and out-of-range accesses return zero data.
  assign resp_data    = (sel_we | ~in_range) ? '0 : mem_RD;
  assign conflict_cnt = cnt;

  // Next-state arbitration on masked requests and drive of the memory pins for the owner.
  always_comb begin
    state_nxt = IDLE;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    cnt_inc   = 1'b0;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    mem_A     = '0;
    mem_WD    = '0;
    mem_WE    = 1'b0;

    if (state == ACCESS) begin
      m0_gnt = ~owner;
      m1_gnt = owner;
      mem_A  = sel_addr;
      mem_WD = sel_wdata;
      // Gated by RST so a reset landing on an ACCESS cycle never commits the write.
      mem_WE = sel_we & in_range & ~RST;
    end

    if (eff_req0 && eff_req1) begin
      state_nxt = ACCESS;
      owner_nxt = rr_ptr;
      rr_nxt    = ~rr_ptr;
      cnt_inc   = 1'b1;
    end else if (eff_req0) begin
      state_nxt = ACCESS;
      owner_nxt = 1'b0;
      rr_nxt    = 1'b1;
    end else if (eff_req1) begin
      state_nxt = ACCESS;
      owner_nxt = 1'b1;
      rr_nxt    = 1'b0;
    end
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      owner  <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Saturating count of arbitrations where both ports were eligible.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (cnt_inc && (cnt != '1)) begin
      cnt <= cnt + CNT_BITS'(1);
    end
  end

  // Capture the owner's response at the edge closing ACCESS; rdata holds until that port's next response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= (state == ACCESS) && !owner;
      m1_rvalid <= (state == ACCESS) && owner;
      m0_err    <= (state == ACCESS) && !owner && !in_range;
      m1_err    <= (state == ACCESS) && owner && !in_range;
      if ((state == ACCESS) && !owner) m0_rdata <= resp_data;
      if ((state == ACCESS) && owner)  m1_rdata <= resp_data;
    end
  end

endmodule
